// File: rtl/uart_rx_tx_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_tx_buffer_if
// Description : Serial lines plus buffer/status observation bundle for
//               uart_rx_tx_buffer.
//               slave  - design side (drives tx and all status outputs)
//               master - environment side (drives rx, observes the rest)
// Ports       : rx, tx, ready, data_store[9:0], data_store2[31:0],
//               bit_count[3:0], bit_count2[3:0], bit_count3[4:0],
//               byte_count[3:0], busy, busy1, busy2, idle
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_tx_buffer_if;
    logic        rx;
    logic        tx;
    logic        ready;
    logic [9:0]  data_store;
    logic [3:0]  bit_count;
    logic [3:0]  bit_count2;
    logic [3:0]  byte_count;
    logic        busy;
    logic        busy2;
    logic        idle;
    logic [4:0]  bit_count3;
    logic [31:0] data_store2;
    logic        busy1;

    modport slave (
        input  rx,
        output tx, ready, data_store, bit_count, bit_count2, byte_count,
               busy, busy2, idle, bit_count3, data_store2, busy1
    );

    modport master (
        output rx,
        input  tx, ready, data_store, bit_count, bit_count2, byte_count,
               busy, busy2, idle, bit_count3, data_store2, busy1
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_tx_buffer
// Description : 8N1 UART that collects NUM_BYTES received bytes into a 32-bit
//               buffer, pulses ready when full, then retransmits the buffer
//               LSB byte first. Counters and flags exposed for observation.
// Ports       : clk  - system clock (rising edge)
//               nrst - asynchronous reset, active HIGH (1 = reset)
//               bus  - uart_rx_tx_buffer_if.slave (rx in, tx/status out)
// Options     : UART_FRAME_CHECK_EN - when defined, frames whose stop bit
//               samples 0 are not stored in the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_tx_buffer #(
    parameter int CLK_FREQ     = 12000000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int NUM_BYTES    = 4
) (
    input  logic                      clk,
    input  logic                      nrst,
    uart_rx_tx_buffer_if.slave        bus
);
    localparam int                 c_cnt_w     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]         c_last_slot = 4'(NUM_BYTES - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // ------------------------------------------------------------------
    // Input synchronizer; flops reset high so no false edge after reset.
    // ------------------------------------------------------------------
    logic r_rx_meta, r_rx_sync, r_rx_prev;

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= bus.rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_t          r_rx_state, w_rx_state_next;
    logic [c_cnt_w-1:0] r_rx_cnt;
    logic [3:0]         r_bit_count;
    logic [9:0]         r_data_store;
    logic               w_rx_sample;
    logic               w_rx_store;
    logic               w_rx_frame_done;
    logic               w_frame_ok;
    logic               w_accept;
    logic               w_full;
    logic               w_tx_done;
    logic [3:0]         r_byte_count;
    logic [31:0]        r_data_store2;
    logic               r_busy1;
    logic               r_ready;

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) r_rx_state <= RX_IDLE;
        else      r_rx_state <= w_rx_state_next;
    end

    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_sample     = 1'b0;
        case (r_rx_state)
            RX_IDLE:  if (r_rx_prev && !r_rx_sync) w_rx_state_next = RX_START;
            RX_START: if (r_rx_cnt == c_half_last) begin
                          // Line back high at mid start bit: treat as glitch.
                          w_rx_sample     = 1'b1;
                          w_rx_state_next = r_rx_sync ? RX_IDLE : RX_DATA;
                      end
            RX_DATA:  if (r_rx_cnt == c_bit_last) begin
                          w_rx_sample = 1'b1;
                          if (r_bit_count == 4'd8) w_rx_state_next = RX_STOP;
                      end
            RX_STOP:  if (r_rx_cnt == c_bit_last) begin
                          w_rx_sample     = 1'b1;
                          w_rx_state_next = RX_IDLE;
                      end
            default:  w_rx_state_next = RX_IDLE;
        endcase
    end

    assign w_rx_store      = w_rx_sample && !((r_rx_state == RX_START) && r_rx_sync);
    assign w_rx_frame_done = w_rx_sample && (r_rx_state == RX_STOP);

`ifdef UART_FRAME_CHECK_EN
    assign w_frame_ok = r_rx_sync;
`else
    assign w_frame_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_rx_cnt     <= '0;
            r_bit_count  <= 4'd0;
            r_data_store <= 10'd0;
        end else begin
            if (r_rx_state == RX_IDLE || w_rx_sample) r_rx_cnt <= '0;
            else                                      r_rx_cnt <= r_rx_cnt + 1'b1;

            if (w_rx_store) begin
                r_data_store[r_bit_count] <= r_rx_sync;
                r_bit_count <= (r_rx_state == RX_STOP) ? 4'd0 : r_bit_count + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Buffer: bytes land in slot byte_count; the last slot locks it.
    // ------------------------------------------------------------------
    assign w_accept = w_rx_frame_done && w_frame_ok && !r_busy1;
    assign w_full   = w_accept && (r_byte_count == c_last_slot);

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_byte_count  <= 4'd0;
            r_data_store2 <= 32'd0;
            r_busy1       <= 1'b0;
            r_ready       <= 1'b0;
        end else begin
            r_ready <= w_full;
            if (w_accept) begin
                // data_store[8:1] is already complete when the stop bit is sampled.
                r_data_store2[{r_byte_count[1:0], 3'b000} +: 8] <= r_data_store[8:1];
                r_byte_count <= r_byte_count + 4'd1;
            end
            if (w_full) begin
                r_busy1 <= 1'b1;
            end else if (w_tx_done) begin
                r_busy1      <= 1'b0;
                r_byte_count <= 4'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmitter. bit_count3 counts data bits sent and doubles as the bit
    // index into the buffer; it wraps to 0 exactly after the last byte.
    // ------------------------------------------------------------------
    tx_state_t          r_tx_state, w_tx_state_next;
    logic [c_cnt_w-1:0] r_tx_cnt;
    logic [3:0]         r_bit_count2;
    logic [4:0]         r_bit_count3;
    logic               w_tx_bit_end;
    logic               w_tx_line;

    assign w_tx_bit_end = (r_tx_cnt == c_bit_last);

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) r_tx_state <= TX_IDLE;
        else      r_tx_state <= w_tx_state_next;
    end

    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_done       = 1'b0;
        w_tx_line       = 1'b1;
        case (r_tx_state)
            TX_IDLE:  if (r_busy1) w_tx_state_next = TX_START;
            TX_START: begin
                          w_tx_line = 1'b0;
                          if (w_tx_bit_end) w_tx_state_next = TX_DATA;
                      end
            TX_DATA:  begin
                          w_tx_line = r_data_store2[r_bit_count3];
                          if (w_tx_bit_end && r_bit_count2 == 4'd8) w_tx_state_next = TX_STOP;
                      end
            TX_STOP:  if (w_tx_bit_end) begin
                          if (r_bit_count3 == 5'd0) begin
                              w_tx_state_next = TX_IDLE;
                              w_tx_done       = 1'b1;
                          end else begin
                              w_tx_state_next = TX_START;
                          end
                      end
            default:  w_tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_tx_cnt     <= '0;
            r_bit_count2 <= 4'd0;
            r_bit_count3 <= 5'd0;
        end else begin
            if (r_tx_state == TX_IDLE || w_tx_bit_end) r_tx_cnt <= '0;
            else                                      r_tx_cnt <= r_tx_cnt + 1'b1;

            if (r_tx_state != TX_IDLE && w_tx_bit_end) begin
                r_bit_count2 <= (r_tx_state == TX_STOP) ? 4'd0 : r_bit_count2 + 4'd1;
                if (r_tx_state == TX_DATA) r_bit_count3 <= r_bit_count3 + 5'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.tx          = w_tx_line;
    assign bus.ready       = r_ready;
    assign bus.data_store  = r_data_store;
    assign bus.bit_count   = r_bit_count;
    assign bus.bit_count2  = r_bit_count2;
    assign bus.bit_count3  = r_bit_count3;
    assign bus.byte_count  = r_byte_count;
    assign bus.data_store2 = r_data_store2;
    assign bus.busy        = (r_rx_state != RX_IDLE);
    assign bus.busy1       = r_busy1;
    assign bus.busy2       = (r_tx_state != TX_IDLE);
    assign bus.idle        = (r_rx_state == RX_IDLE) && !r_busy1 && (r_tx_state == TX_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_tx_buffer
// Description : Self-checking bench for uart_rx_tx_buffer. Runs the design at
//               a shortened bit period so the whole sequence stays brief.
//               A frame-level reference model predicts buffer contents, byte
//               counts and the retransmitted byte stream; an independent UART
//               decoder watches tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_tx_buffer;
    localparam int c_clk_freq = 12000000;
    localparam int c_baud     = 375000;
    localparam int c_cpb      = c_clk_freq / c_baud;   // 32 clocks per bit
`ifdef UART_FRAME_CHECK_EN
    localparam bit c_frame_check = 1'b1;
`else
    localparam bit c_frame_check = 1'b0;
`endif

    logic clk  = 1'b0;
    logic nrst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    uart_rx_tx_buffer_if u_if ();

    uart_rx_tx_buffer #(
        .CLK_FREQ  (c_clk_freq),
        .BAUD      (c_baud),
        .NUM_BYTES (4)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (u_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- observers (no checking here) ----------------
    int   ready_pulses = 0;
    int   ready_high   = 0;
    int   ready_cyc    = 0;
    logic ready_q      = 1'b0;
    always @(negedge clk) begin
        if (u_if.ready === 1'b1) begin
            ready_high++;
            if (!ready_q) begin
                ready_pulses++;
                ready_cyc = cyc;
            end
        end
        ready_q = (u_if.ready === 1'b1);
    end

    int busy_run  = 0;
    int busy_last = 0;
    always @(negedge clk) begin
        if (u_if.busy === 1'b1) busy_run++;
        else if (busy_run != 0) begin
            busy_last = busy_run;
            busy_run  = 0;
        end
    end

    // Independent 8N1 decoder on tx, sampling at bit centres.
    logic [9:0] dec_frames[$];
    int         dec_start_cyc[$];
    logic [9:0] dec_f;
    initial begin
        forever begin
            @(negedge clk);
            if (nrst === 1'b0 && u_if.tx === 1'b0) begin
                dec_start_cyc.push_back(cyc);
                repeat (c_cpb / 2) @(negedge clk);
                dec_f[0] = u_if.tx;
                for (int i = 1; i < 10; i++) begin
                    repeat (c_cpb) @(negedge clk);
                    dec_f[i] = u_if.tx;
                end
                dec_frames.push_back(dec_f);
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] m_buf[4];
    int         m_count  = 0;
    bit         m_locked = 1'b0;
    logic [9:0] m_ds     = 10'd0;
    logic [7:0] m_tx[$];

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_buf[k] = 8'd0;
        m_count  = 0;
        m_locked = 1'b0;
        m_ds     = 10'd0;
    endtask

    task automatic model_frame(input logic [7:0] d, input logic stop);
        m_ds = {stop, d, 1'b0};
        if (m_locked) return;
        if (c_frame_check && !stop) return;
        m_buf[m_count] = d;
        m_count++;
        if (m_count == 4) begin
            m_locked = 1'b1;
            for (int k = 0; k < 4; k++) m_tx.push_back(m_buf[k]);
        end
    endtask

    function automatic logic [31:0] m_ds2();
        return {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string p);
        chk({p, "_tx"},          32'(u_if.tx),          32'd1);
        chk({p, "_idle"},        32'(u_if.idle),        32'd1);
        chk({p, "_ready"},       32'(u_if.ready),       32'd0);
        chk({p, "_data_store"},  32'(u_if.data_store),  32'd0);
        chk({p, "_data_store2"}, u_if.data_store2,      32'd0);
        chk({p, "_bit_count"},   32'(u_if.bit_count),   32'd0);
        chk({p, "_bit_count2"},  32'(u_if.bit_count2),  32'd0);
        chk({p, "_bit_count3"},  32'(u_if.bit_count3),  32'd0);
        chk({p, "_byte_count"},  32'(u_if.byte_count),  32'd0);
        chk({p, "_busy"},        32'(u_if.busy),        32'd0);
        chk({p, "_busy1"},       32'(u_if.busy1),       32'd0);
        chk({p, "_busy2"},       32'(u_if.busy2),       32'd0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            u_if.rx = f[i];
            repeat (c_cpb) @(negedge clk);
        end
        u_if.rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Send one frame, update the model, compare the visible RX/buffer state.
    task automatic xfer(input string p, input logic [7:0] d, input logic stop);
        send_frame(d, stop);
        model_frame(d, stop);
        chk({p, "_data_store"},  32'(u_if.data_store), 32'(m_ds));
        chk({p, "_byte_count"},  32'(u_if.byte_count), 32'(m_count));
        chk({p, "_data_store2"}, u_if.data_store2,     m_ds2());
        chk({p, "_busy"},        32'(u_if.busy),       32'd0);
    endtask

    task automatic wait_tx_done(input string p);
        int n;
        n = 0;
        while (u_if.idle !== 1'b1 && n < 60 * c_cpb) begin
            @(negedge clk);
            n++;
        end
        chk({p, "_tx_done_in_time"}, 32'(n < 60 * c_cpb), 32'd1);
        m_count  = 0;
        m_locked = 1'b0;
        repeat (4) @(negedge clk);
        chk({p, "_busy1_after"},      32'(u_if.busy1),      32'd0);
        chk({p, "_busy2_after"},      32'(u_if.busy2),      32'd0);
        chk({p, "_byte_count_after"}, 32'(u_if.byte_count), 32'd0);
        chk({p, "_bit_count3_after"}, 32'(u_if.bit_count3), 32'd0);
        chk({p, "_tx_after"},         32'(u_if.tx),         32'd1);
        chk({p, "_ds2_retained"},     u_if.data_store2,     m_ds2());
    endtask

    task automatic check_tx_stream(input string p, input int rdy_cyc);
        logic [9:0] got;
        logic [7:0] want;
        chk({p, "_tx_frame_count"}, 32'(dec_frames.size()), 32'(m_tx.size()));
        if (dec_start_cyc.size() > 0)
            chk({p, "_tx_start_delay"}, 32'(dec_start_cyc[0] - rdy_cyc), 32'd1);
        for (int i = 1; i < dec_start_cyc.size(); i++)
            chk($sformatf("%s_tx_spacing%0d", p, i),
                32'(dec_start_cyc[i] - dec_start_cyc[i-1]), 32'(10 * c_cpb));
        for (int i = 0; i < 4 && dec_frames.size() > 0 && m_tx.size() > 0; i++) begin
            got  = dec_frames.pop_front();
            want = m_tx.pop_front();
            chk($sformatf("%s_tx_frame%0d", p, i), 32'(got), 32'({1'b1, want, 1'b0}));
        end
        dec_frames.delete();
        dec_start_cyc.delete();
        m_tx.delete();
    endtask

    // ---------------- directed sequence ----------------
    int         rp0, rh0;
    logic [7:0] lock_byte;
    initial begin
        u_if.rx = 1'b1;
        nrst    = 1'b1;
        model_reset();

        // Reset held for 100 clocks.
        repeat (100) @(negedge clk);
        check_reset_state("rst_hold");
        nrst = 1'b0;
        repeat (200) @(negedge clk);
        chk("idle_line_idle", 32'(u_if.idle), 32'd1);
        chk("idle_line_busy", 32'(u_if.busy), 32'd0);
        chk("idle_line_tx",   32'(u_if.tx),   32'd1);

        // Single byte.
        rp0 = ready_pulses;
        xfer("single", 8'hA5, 1'b1);
        chk("single_raw_frame", 32'(u_if.data_store), 32'h34A);
        chk("single_no_ready",  32'(ready_pulses - rp0), 32'd0);
        chk("single_busy_len_window",
            32'((busy_last >= 9 * c_cpb) && (busy_last <= 10 * c_cpb)), 32'd1);

        // Short low glitch on rx.
        u_if.rx = 1'b0;
        repeat (c_cpb / 4) @(negedge clk);
        chk("glitch_busy_seen", 32'(u_if.busy), 32'd1);
        u_if.rx = 1'b1;
        repeat (c_cpb) @(negedge clk);
        chk("glitch_busy_drop",  32'(u_if.busy),       32'd0);
        chk("glitch_byte_count", 32'(u_if.byte_count), 32'(m_count));
        chk("glitch_data_store", 32'(u_if.data_store), 32'(m_ds));

        // Clear, then fill the buffer with a known pattern.
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        nrst = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        dec_frames.delete();
        dec_start_cyc.delete();
        rp0 = ready_pulses;
        rh0 = ready_high;
        xfer("fill0", 8'h11, 1'b1);
        xfer("fill1", 8'h22, 1'b1);
        xfer("fill2", 8'h33, 1'b1);
        xfer("fill3", 8'h44, 1'b1);
        chk("fill_ds2_const",   u_if.data_store2, 32'h44332211);
        chk("fill_ready_pulse", 32'(ready_pulses - rp0), 32'd1);
        chk("fill_ready_width", 32'(ready_high - rh0),   32'd1);
        chk("fill_busy1",       32'(u_if.busy1),         32'd1);

        // Byte arriving while the buffer is locked is dropped.
        lock_byte = 8'($urandom_range(0, 255));
        xfer("lock", lock_byte, 1'b1);
        chk("lock_byte_count", 32'(u_if.byte_count), 32'd4);
        chk("lock_busy1",      32'(u_if.busy1),      32'd1);
        wait_tx_done("fill");
        chk("fill_idle", 32'(u_if.idle), 32'd1);
        check_tx_stream("fill", ready_cyc);

        // Randomized buffers, with occasional bad stop bits.
        for (int r = 0; r < 3; r++) begin
            rp0 = ready_pulses;
            for (int n = 0; n < 16 && !m_locked; n++)
                xfer($sformatf("rnd%0d_%0d", r, n), 8'($urandom_range(0, 255)),
                     ($urandom_range(0, 3) != 0));
            chk($sformatf("rnd%0d_ready", r), 32'(ready_pulses - rp0), 32'(m_locked));
            chk($sformatf("rnd%0d_busy1", r), 32'(u_if.busy1),         32'(m_locked));
            if (m_locked) begin
                wait_tx_done($sformatf("rnd%0d", r));
                check_tx_stream($sformatf("rnd%0d", r), ready_cyc);
            end
        end

        // Frame with stop bit 0.
        xfer("frame_err", 8'h5A, 1'b0);
        chk("frame_err_raw", 32'(u_if.data_store), 32'h0B4);

        // Reset asserted in the middle of a received frame.
        u_if.rx = 1'b0;
        repeat (3 * c_cpb) @(negedge clk);
        chk("midrx_busy", 32'(u_if.busy), 32'd1);
        @(posedge clk);
        #2 nrst = 1'b1;
        #1 check_reset_state("midrx_rst");
        u_if.rx = 1'b1;
        repeat (10) @(negedge clk);
        nrst = 1'b0;
        model_reset();
        repeat (2 * c_cpb) @(negedge clk);
        chk("post_rst_idle", 32'(u_if.idle), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_rx_tx_buffer.md
Name: uart_rx_tx_buffer

Overview:
- UART receive-buffer-retransmit block (8N1, 9600 baud, 12 MHz clock).
- Receives bytes on rx and packs four of them into a 32-bit buffer.
- When the buffer is full, it signals ready and retransmits the four bytes, LSB-byte first, on tx.
- Exposes internal counters and status flags for debug and observation.

Parameters:
- CLK_FREQ, 12000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bits/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (1250), clocks per bit period.
- NUM_BYTES, 4, bytes per buffer; must match data_store2 width / 8.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous, active-high reset. The port keeps the codebase name; 1 = reset.
- rx  in  1  serial input, idles high.
- tx  out  1  serial output, idles high.
- ready  out  1  one-cycle pulse when the buffer becomes full.
- data_store  out  10  last received raw frame: [0]=start, [8:1]=data LSB-first, [9]=stop.
- bit_count  out  4  RX bit index in the current frame, 0..9.
- bit_count2  out  4  TX bit index in the current frame, 0..9.
- byte_count  out  4  bytes stored in the buffer, 0..4.
- busy  out  1  RX frame in progress.
- busy2  out  1  TX frame on the line.
- idle  out  1  equals !busy && !busy1 && !busy2.
- bit_count3  out  5  TX data bits sent from the buffer, 0..31.
- data_store2  out  32  buffer; byte k occupies [8k+7:8k].
- busy1  out  1  buffer locked and retransmission pending or active.

Behaviour:
- Reset (async, nrst=1):
  - tx=1, idle=1.
  - All counters, busy flags, ready, data_store and data_store2 = 0.
  - Reset mid-frame aborts RX and TX immediately.
- Input conditioning: rx passes through a 2-flop synchronizer.
- RX state machine: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a falling edge on the synchronized rx enters START; busy=1, bit_count=0.
  - START: at CLKS_PER_BIT/2 (625) clocks, rx is resampled. If high, the frame is a glitch: return to IDLE, busy=0, nothing stored.
  - DATA and STOP: sample every CLKS_PER_BIT clocks. Each sample shifts into data_store at index bit_count, then bit_count increments.
  - STOP: after the stop sample, data_store is complete. bit_count returns to 0, busy=0, state returns to IDLE in the same cycle.
- Byte accept:
  - On stop-bit sample, if busy1=0, the byte goes to data_store2[8*byte_count +: 8] and byte_count increments.
  - If busy1=1, the byte is dropped (data_store still updates).
- Buffer full:
  - Storing the 4th byte sets byte_count=4, pulses ready for exactly one clock, and sets busy1=1.
  - TX starts on the next clock.
- TX state machine: IDLE -> START -> DATA -> STOP, per byte, bytes 0..3 back-to-back.
  - Each bit lasts CLKS_PER_BIT clocks.
  - busy2=1 from start bit through end of stop bit.
  - bit_count2 steps 0..9.
  - bit_count3 increments on each data bit sent and wraps 31->0 after the last.
- TX complete: after byte 3's stop bit, busy1=0, busy2=0, byte_count=0, tx=1. data_store2 retains its contents until overwritten.
- Simultaneous events: RX and TX run independently; an RX frame may proceed during TX.
- Counter rules: counters never exceed stated ranges; no other wrap.

Optional Feature:
- Macro: UART_FRAME_CHECK_EN.
- Defined: a received frame whose stop bit samples 0 is a framing error. The byte is not stored, byte_count is unchanged, and data_store still shows the raw frame.
- Undefined: the stop bit is ignored and every completed frame is accepted.

Test Plan:
- Reset: hold nrst=1 for 100 clocks -> tx=1, idle=1, all counters 0; after release, rx=1 for 2 ms -> still idle.
- Single byte: send 0xA5 at 104.17 us/bit -> data_store=10'h34A, byte_count=1, busy high for about 10 bit times then low, ready stays 0.
- Four bytes: send 0x11, 0x22, 0x33, 0x44 -> data_store2=32'h44332211, one-cycle ready, busy1=1.
  - tx then emits four 8N1 frames 0x11..0x44 at 1250 clocks/bit.
  - Afterwards busy1=0, byte_count=0, idle=1.
- Glitch: rx low for 300 clocks then high -> no frame, busy drops, byte_count unchanged.
- Lock and reset: send a byte during retransmit -> dropped, byte_count stays 4; assert nrst mid-RX frame -> all outputs at reset values at once.
- Framing (UART_FRAME_CHECK_EN defined): 0x5A with stop=0 -> byte_count unchanged, data_store=10'h0B4.
